// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU type definitions used by the TLB maintenance path
//
// Purpose : one place for the TLB geometry, the TLB op encoding and the
//           packed TLB entry layout, so the controller, the Random counter
//           and the TLB array all agree on widths.
// Ports   : none (package).
package cpu_defs;

  localparam int TLB_ENTRIES_NUM = 16;
  localparam int TLB_INDEX_W     = $clog2(TLB_ENTRIES_NUM);

  typedef logic [TLB_INDEX_W-1:0] tlb_index_t;

  typedef enum logic [1:0] {
    TLBR  = 2'd0,
    TLBWI = 2'd1,
    TLBWR = 2'd2,
    TLBP  = 2'd3
  } tlb_op_t;

  // MIPS-style dual-page entry: one VPN2 maps an even/odd page pair.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  // Only the two write ops modify the array and force a refetch.
  function automatic logic is_tlb_write(input tlb_op_t op);
    return (op == TLBWI) || (op == TLBWR);
  endfunction

endpackage

// File: rtl/tlb_random_gen.sv
// rtl/tlb_random_gen.sv - CP0 Random / Wired counter
//
// Purpose : Random counts down every cycle from ENTRIES-1 and reloads to
//           ENTRIES-1 after reaching Wired (or 0), so TLBWR never lands in
//           the wired (locked) region below Wired.
// Ports   : clk, rst (async, active-low)
//           wired_we, wired_wdata : Wired register write
//           random_out            : current Random value
module tlb_random_gen
  import cpu_defs::*;
#(
  parameter int ENTRIES = TLB_ENTRIES_NUM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wired_we,
  input  tlb_index_t wired_wdata,
  output tlb_index_t random_out
);

  localparam tlb_index_t TOP = tlb_index_t'(ENTRIES - 1);

  tlb_index_t wired_q;
  tlb_index_t random_q;
  tlb_index_t random_d;

  // A Wired value beyond the array leaves no replaceable entries; park
  // Random at the top instead of letting it wrap through the array.
  always_comb begin
    random_d = random_q - tlb_index_t'(1);
    if (wired_we || (int'(wired_q) >= ENTRIES) ||
        (random_q == wired_q) || (random_q == '0)) begin
      random_d = TOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wired_q  <= '0;
      random_q <= TOP;
    end else begin
      random_q <= random_d;
      if (wired_we) begin
        wired_q <= wired_wdata;
      end
    end
  end

  assign random_out = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLBR/TLBWI/TLBWR/TLBP sequencing controller
//
// Purpose : accepts one TLB maintenance op at a time and runs it through
//           IDLE -> ISSUE -> FINISH. The TLB array is accessed in ISSUE,
//           completion is signalled in FINISH.
// Ports   : clk, rst (async, active-low)
//           op_valid/op_ready/op_type/op_abort : op request handshake
//           cp0_index, cp0_entry_hi, cp0_entry  : CP0 operands
//           wired_we, wired_wdata, random_out   : Wired/Random registers
//           tlbrw_index/we/wdata/rdata           : TLB array read/write port
//           tlbp_entry_hi, tlbp_index           : TLB array probe port
//           done, done_op, rd_entry, probe_index, flush_req : results
module tlb_op_ctrl
  import cpu_defs::*;
#(
  parameter int ENTRIES = TLB_ENTRIES_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  tlb_op_t     op_type,
  input  logic        op_abort,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_entry_hi,
  input  tlb_entry_t  cp0_entry,
  input  logic        wired_we,
  input  tlb_index_t  wired_wdata,
  output tlb_index_t  random_out,
  output tlb_index_t  tlbrw_index,
  output logic        tlbrw_we,
  output tlb_entry_t  tlbrw_wdata,
  input  tlb_entry_t  tlbrw_rdata,
  output logic [31:0] tlbp_entry_hi,
  input  logic [31:0] tlbp_index,
  output logic        done,
  output tlb_op_t     done_op,
  output tlb_entry_t  rd_entry,
  output logic [31:0] probe_index,
  output logic        flush_req
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FINISH
  } state_t;

  state_t  state;
  state_t  state_d;
  tlb_op_t op_q;
  logic    accept;

  // Only the index bits of CP0 Index address the array.
  wire unused_index_bits = ^cp0_index[31:TLB_INDEX_W];

  tlb_random_gen #(
    .ENTRIES (ENTRIES)
  ) u_random (
    .clk         (clk),
    .rst         (rst),
    .wired_we    (wired_we),
    .wired_wdata (wired_wdata),
    .random_out  (random_out)
  );

  assign accept = op_valid && op_ready;

  always_comb begin
    state_d   = state;
    op_ready  = 1'b0;
    tlbrw_we  = 1'b0;
    done      = 1'b0;
    done_op   = TLBR;
    flush_req = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Abort must kill the write in the same cycle, so the strobe is
        // decoded combinationally rather than registered.
        tlbrw_we = is_tlb_write(op_q) && !op_abort;
        state_d  = op_abort ? S_IDLE : S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        done_op   = op_q;
        flush_req = is_tlb_write(op_q);
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The operand latches drive the array port directly; they are loaded at
  // acceptance, so they already hold the right values throughout ISSUE.
  // For TLBWR, Random is sampled at acceptance, before any coincident
  // Wired write reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      op_q          <= TLBR;
      tlbrw_index   <= '0;
      tlbrw_wdata   <= '0;
      tlbp_entry_hi <= '0;
      rd_entry      <= '0;
      probe_index   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q          <= op_type;
        tlbrw_index   <= (op_type == TLBWR) ? random_out : cp0_index[TLB_INDEX_W-1:0];
        tlbrw_wdata   <= cp0_entry;
        tlbp_entry_hi <= cp0_entry_hi;
      end
      if ((state == S_ISSUE) && !op_abort) begin
        if (op_q == TLBR) begin
          rd_entry <= tlbrw_rdata;
        end
        if (op_q == TLBP) begin
          probe_index <= tlbp_index;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - self-checking bench for tlb_op_ctrl
module tb_tlb_op_ctrl;
  import cpu_defs::*;

  localparam int N = TLB_ENTRIES_NUM;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  tlb_op_t     op_type = TLBR;
  logic        op_abort = 1'b0;
  logic [31:0] cp0_index = '0;
  logic [31:0] cp0_entry_hi = '0;
  tlb_entry_t  cp0_entry = '0;
  logic        wired_we = 1'b0;
  tlb_index_t  wired_wdata = '0;
  tlb_index_t  random_out;
  tlb_index_t  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata;
  tlb_entry_t  tlbrw_rdata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;
  logic        done;
  tlb_op_t     done_op;
  tlb_entry_t  rd_entry;
  logic [31:0] probe_index;
  logic        flush_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .op_abort(op_abort), .cp0_index(cp0_index),
    .cp0_entry_hi(cp0_entry_hi), .cp0_entry(cp0_entry),
    .wired_we(wired_we), .wired_wdata(wired_wdata), .random_out(random_out),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .done(done), .done_op(done_op), .rd_entry(rd_entry), .probe_index(probe_index),
    .flush_req(flush_req)
  );

  function automatic tlb_entry_t init_entry(input int i);
    tlb_entry_t e = '0;
    e.vpn2 = 19'h100 + 19'(i);
    e.g    = 1'b1;
    e.pfn0 = 20'(i * 2);
    e.v0   = 1'b1;
    return e;
  endfunction

  function automatic logic hit(input tlb_entry_t e, input logic [31:0] ehi);
    return (e.vpn2 == ehi[31:13]) && (e.g || (e.asid == ehi[7:0]));
  endfunction

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t e = tlb_entry_t'({$urandom, $urandom, $urandom});
    e.vpn2[18] = 1'b1;
    return e;
  endfunction

  // TLB array seen by the DUT
  tlb_entry_t mem [N];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < N; i++) mem[i] <= init_entry(i);
      mem_ready <= 1'b1;
    end else if (tlbrw_we) begin
      mem[tlbrw_index] <= tlbrw_wdata;
    end
  end
  assign tlbrw_rdata = mem[tlbrw_index];
  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--) if (hit(mem[i], tlbp_entry_hi)) tlbp_index = 32'(i);
  end

  // Reference model: TLB contents as ops should leave them, and Random as
  // a closed form of cycles elapsed since the last reload event.
  tlb_entry_t ref_tlb [N];
  int rnd_n = 0;
  int rnd_wired = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_n <= 0;
      rnd_wired <= 0;
    end else if (wired_we) begin
      rnd_n <= 0;
      rnd_wired <= int'(wired_wdata);
    end else begin
      rnd_n <= rnd_n + 1;
    end
  end
  function automatic int exp_random();
    return (N - 1) - (rnd_n % (N - rnd_wired));
  endfunction

  function automatic logic [31:0] ref_probe(input logic [31:0] ehi);
    logic [31:0] r = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--) if (hit(ref_tlb[i], ehi)) r = 32'(i);
    return r;
  endfunction

  tlb_entry_t  exp_rd = '0;
  logic [31:0] exp_probe = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("random_out", 128'(random_out), 128'(exp_random()));
  endtask

  task automatic run_op(input tlb_op_t op, input tlb_index_t idx, input logic [31:0] ehi,
                        input tlb_entry_t ent, input logic abort, input logic do_wired,
                        input tlb_index_t wval, input logic xwe, input logic xdone,
                        input logic xflush);
    tlb_index_t  tgt;
    logic [31:0] r;
    check("op_ready_idle", 128'(op_ready), 128'(1));
    tgt = (op == TLBWR) ? tlb_index_t'(exp_random()) : idx;
    r = $urandom;
    op_valid = 1'b1;
    op_type = op;
    cp0_index = {r[31:TLB_INDEX_W], idx};
    cp0_entry_hi = ehi;
    cp0_entry = ent;
    wired_we = do_wired;
    wired_wdata = wval;
    tick();
    // ISSUE: scramble operands and keep requesting to show they are ignored
    wired_we = 1'b0;
    op_type = tlb_op_t'($urandom_range(0, 3));
    cp0_index = $urandom;
    cp0_entry_hi = $urandom;
    cp0_entry = rand_entry();
    op_abort = abort;
    #1;
    check("issue_we", 128'(tlbrw_we), 128'(xwe));
    check("issue_ready", 128'(op_ready), 128'(0));
    check("issue_ehi", 128'(tlbp_entry_hi), 128'(ehi));
    if (op != TLBP) check("issue_index", 128'(tlbrw_index), 128'(tgt));
    if (xwe) check("issue_wdata", 128'(tlbrw_wdata), 128'(ent));
    tick();
    op_valid = 1'b0;
    op_abort = 1'b0;
    if (!abort && op == TLBR) exp_rd = ref_tlb[idx];
    if (!abort && op == TLBP) exp_probe = ref_probe(ehi);
    if (xwe) ref_tlb[tgt] = ent;
    check("fin_done", 128'(done), 128'(xdone));
    check("fin_done_op", 128'(done_op), 128'(xdone ? op : TLBR));
    check("fin_flush", 128'(flush_req), 128'(xflush));
    check("fin_we", 128'(tlbrw_we), 128'(0));
    check("rd_entry", 128'(rd_entry), 128'(exp_rd));
    check("probe_index", 128'(probe_index), 128'(exp_probe));
    check("fin_ready", 128'(op_ready), 128'(abort));
    if (!abort) begin
      tick();
      check("post_done", 128'(done), 128'(0));
      check("post_ready", 128'(op_ready), 128'(1));
    end
  endtask

  typedef struct {
    tlb_op_t     op;
    tlb_index_t  idx;
    logic [31:0] ehi;
    logic        abort;
    logic        xwe;
    logic        xdone;
    logic        xflush;
    logic [31:0] xprobe;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

  initial begin
    tlb_op_t     op;
    logic [31:0] ehi;
    logic        ab;
    vecs[0] = '{TLBWI, 4'd5, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{TLBR,  4'd5, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{TLBP,  4'd0, {19'h103, 13'h0}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0003};
    vecs[3] = '{TLBP,  4'd0, {19'h00fff, 13'h0}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000};
    vecs[4] = '{TLBWR, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{TLBWR, 4'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[6] = '{TLBR,  4'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{TLBP,  4'd0, {19'h103, 13'h0}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < N; i++) ref_tlb[i] = init_entry(i);

    // reset state
    tick();
    tick();
    check("rst_ready", 128'(op_ready), 128'(1));
    check("rst_done", 128'(done), 128'(0));
    check("rst_done_op", 128'(done_op), 128'(0));
    check("rst_flush", 128'(flush_req), 128'(0));
    check("rst_we", 128'(tlbrw_we), 128'(0));
    check("rst_rd_entry", 128'(rd_entry), 128'(0));
    check("rst_probe", 128'(probe_index), 128'(0));
    check("rst_index", 128'(tlbrw_index), 128'(0));
    check("rst_wdata", 128'(tlbrw_wdata), 128'(0));
    check("rst_ehi", 128'(tlbp_entry_hi), 128'(0));
    check("rst_random", 128'(random_out), 128'(15));
    rst = 1'b1;
    check("rel_ready", 128'(op_ready), 128'(1));
    tick();

    // table-driven ops
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].idx, vecs[i].ehi, rand_entry(), vecs[i].abort, 1'b0, '0,
             vecs[i].xwe, vecs[i].xdone, vecs[i].xflush);
      if (vecs[i].op == TLBP && !vecs[i].abort)
        check("probe_const", 128'(probe_index), 128'(vecs[i].xprobe));
    end

    // TLBWR accepted together with a Wired write uses the old Random
    run_op(TLBWR, 4'd0, 32'h0, rand_entry(), 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);

    // Random sequence with Wired = 4, then a Wired write of 8 mid-count
    wired_we = 1'b1;
    wired_wdata = 4'd4;
    tick();
    wired_we = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      check("rand_w4", 128'(random_out), 128'((k <= 11) ? 15 - k : 15));
      tick();
    end
    wired_we = 1'b1;
    wired_wdata = 4'd8;
    tick();
    wired_we = 1'b0;
    check("rand_w8_reload", 128'(random_out), 128'(15));
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("rand_w8", 128'(random_out), 128'((k <= 7) ? 15 - k : 15));
    end

    // reset during ISSUE of a TLBWI
    op_valid = 1'b1;
    op_type = TLBWI;
    cp0_index = 32'd9;
    cp0_entry = rand_entry();
    tick();
    op_valid = 1'b0;
    check("rst_mid_we_before", 128'(tlbrw_we), 128'(1));
    rst = 1'b0;
    #1;
    check("rst_mid_we", 128'(tlbrw_we), 128'(0));
    check("rst_mid_done", 128'(done), 128'(0));
    tick();
    tick();
    #2;
    rst = 1'b1;
    exp_rd = '0;
    exp_probe = '0;
    check("rst_mid_ready", 128'(op_ready), 128'(1));
    check("rst_mid_random", 128'(random_out), 128'(15));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_mid_nodone", 128'(done), 128'(0));
      check("rst_mid_nowe", 128'(tlbrw_we), 128'(0));
    end
    check("rst_mid_mem", 128'(mem[9]), 128'(ref_tlb[9]));

    // randomized ops with random idle gaps and Wired writes
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 3) == 0) begin
          wired_we = 1'b1;
          wired_wdata = tlb_index_t'($urandom_range(0, N - 1));
        end
        tick();
        wired_we = 1'b0;
      end
      op = tlb_op_t'($urandom_range(0, 3));
      ab = ($urandom_range(0, 4) == 0);
      ehi = $urandom;
      if ($urandom_range(0, 1) == 1) ehi[31:13] = ref_tlb[$urandom_range(0, N - 1)].vpn2;
      run_op(op, tlb_index_t'($urandom_range(0, N - 1)), ehi, rand_entry(), ab,
             ($urandom_range(0, 5) == 0), tlb_index_t'($urandom_range(0, N - 1)),
             is_tlb_write(op) && !ab, !ab, is_tlb_write(op) && !ab);
    end
    for (int i = 0; i < N; i++) check("mem_final", 128'(mem[i]), 128'(ref_tlb[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: op_valid  in  1  TLB op request; op_ready  out  1  controller idle, can accept; op_type  in  2  tlb_op_t: TLBR/TLBWI/TLBWR/TLBP.
REQ-003 SHALL have ports: op_abort  in  1  kill in-flight op; cp0_index  in  32  CP0 Index; cp0_entry_hi  in  32  CP0 EntryHi; cp0_entry  in  tlb_entry_t  entry assembled from CP0.
REQ-004 SHALL have ports: wired_we  in  1  Wired write strobe; wired_wdata  in  tlb_index_t  new Wired value; random_out  out  tlb_index_t  CP0 Random value.
REQ-005 SHALL have ports: tlbrw_index  out  tlb_index_t; tlbrw_we  out  1; tlbrw_wdata  out  tlb_entry_t; tlbrw_rdata  in  tlb_entry_t; tlbp_entry_hi  out  32; tlbp_index  in  32 (TLB array side).
REQ-006 SHALL have ports: done  out  1  one-cycle completion pulse; done_op  out  2  op completed; rd_entry  out  tlb_entry_t  TLBR result; probe_index  out  32  TLBP result; flush_req  out  1  pipeline refetch after TLB write.
REQ-007 SHALL use parameter: ENTRIES, `TLB_ENTRIES_NUM, number of TLB entries; index width $clog2(ENTRIES).

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> FINISH -> IDLE; op_ready = (state == IDLE), combinational.
REQ-009 SHALL accept op on cycle T when op_valid && op_ready; latch op_type, cp0_index low bits, cp0_entry_hi, cp0_entry, and (TLBWR) current random_out.
REQ-010 SHALL in ISSUE (T+1) drive tlbrw_index = latched index (TLBR/TLBWI) or latched random (TLBWR), tlbrw_wdata = latched entry, tlbp_entry_hi = latched EntryHi.
REQ-011 SHALL assert tlbrw_we for exactly the ISSUE cycle, only for TLBWI/TLBWR, never in any other state.
REQ-012 SHALL in ISSUE register tlbrw_rdata into rd_entry (TLBR) and tlbp_index into probe_index (TLBP); both hold until next TLBR/TLBP completes.
REQ-013 SHALL in FINISH (T+2) assert done=1 and done_op=latched op for one cycle; flush_req=1 in same cycle for TLBWI/TLBWR only.
REQ-014 SHALL on op_abort in ISSUE suppress tlbrw_we and result capture, go to IDLE, no done; op_abort in FINISH or IDLE ignored.
REQ-015 SHALL keep Random counter: decrement each cycle; when Random == Wired or Random == 0, next = ENTRIES-1.
REQ-016 SHALL on wired_we set Wired = wired_wdata and Random = ENTRIES-1 next cycle; Wired >= ENTRIES clamps Random at ENTRIES-1.
REQ-017 SHALL on wired_we coincident with TLBWR acceptance latch pre-update Random.
REQ-018 SHALL ignore op_valid while op_ready=0; back-to-back ops accepted no earlier than FINISH+1 (3-cycle throughput).

Reset
REQ-019 SHALL on rst=0 asynchronously force: state=IDLE, Random=ENTRIES-1, Wired=0, tlbrw_we=0, done=0, done_op=0, flush_req=0, rd_entry=0, probe_index=0, tlbrw_index=0, tlbrw_wdata=0, tlbp_entry_hi=0.
REQ-020 SHALL on reset mid-op drop the op: no write, no done after release.
REQ-021 SHALL release reset with op_ready=1 in first cycle.

Structure
REQ-022 SHALL place tlb_op_t, tlb_index_t, tlb_entry_t and TLB_ENTRIES_NUM in shared cpu_defs package.
REQ-023 SHALL contain one sub-module tlb_random_gen (Random/Wired counter); FSM inline.

Verification
REQ-024 SHALL check TLBWI idx 5: accept T -> T+1 tlbrw_we=1, tlbrw_index=5; T+2 done=1, done_op=TLBWI, flush_req=1.
REQ-025 SHALL check TLBP hit entry 3 -> probe_index=0x00000003 at T+2; miss -> probe_index=0x80000000, no tlbrw_we.
REQ-026 SHALL check ENTRIES=16, Wired=4: Random 15,14,..,4,15; wired_we=8 -> Random=15 next cycle.
REQ-027 SHALL check op_abort in ISSUE of TLBWR -> tlbrw_we=0, done=0, op_ready=1 at T+2.
REQ-028 SHALL check rst=0 during ISSUE of TLBWI -> tlbrw_we=0 immediately, done never pulses, Random=15 after release.
